// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one signed less-than comparator among REQS
// requesters, with a one-entry response buffer tagged by requester ID.

module comparator_lt #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);

  // One extra sign bit keeps a - b from overflowing, so the top bit is the answer.
  logic [N:0] diff;

  assign diff = {a_i[N-1], a_i} - {b_i[N-1], b_i};
  assign lt_o = diff[N];

endmodule

module comparator_arbiter #(
  parameter  int unsigned N    = 32,
  parameter  int unsigned REQS = 4,
  localparam int unsigned IW   = (REQS > 1) ? $clog2(REQS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  input  logic [REQS*N-1:0] req_a,
  input  logic [REQS*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic              rsp_lt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic            rsp_lt_q, rsp_lt_d;

  logic            free;
  logic            gnt_found;
  logic            gnt_en;
  logic [IW-1:0]   gnt_idx;
  logic [REQS-1:0] gnt_oh;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;
  logic            cmp_lt;

  assign free   = (state_q == EMPTY) | rsp_ready;
  assign gnt_en = rst_n & free & gnt_found;

  // Two passes: indices at or above ptr first, then the wrapped ones below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      if (!gnt_found && req_valid[i] && (i >= 32'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < REQS; i++) begin
      if (!gnt_found && req_valid[i] && (i < 32'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      if (32'(gnt_idx) == i) begin
        a_sel     = req_a[i*N +: N];
        b_sel     = req_b[i*N +: N];
        gnt_oh[i] = gnt_en;
      end
    end
  end

  assign req_ready = gnt_oh;

  comparator_lt #(
    .N (N)
  ) u_cmp (
    .a_i  (a_sel),
    .b_i  (b_sel),
    .lt_o (cmp_lt)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    rsp_lt_d = rsp_lt_q;
    if (gnt_en) begin
      state_d  = FULL;
      ptr_d    = (32'(gnt_idx) == REQS - 1) ? '0 : gnt_idx + IW'(1);
      rsp_id_d = gnt_idx;
      rsp_lt_d = cmp_lt;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      rsp_id_q <= '0;
      rsp_lt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      rsp_lt_q <= rsp_lt_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_lt    = rsp_lt_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Randomized and directed checks of comparator_arbiter against a transaction-level model.

module tb_comparator_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic         rsp_lt;

  logic         rst2_n;
  logic [2:0]   req_valid2;
  logic [2:0]   req_ready2;
  logic [23:0]  req_a2;
  logic [23:0]  req_b2;
  logic         rsp_valid2;
  logic         rsp_ready2;
  logic [1:0]   rsp_id2;
  logic         rsp_lt2;

  int n_checks = 0;
  int n_err    = 0;

  int m_ptr, m_id, last_grant;
  bit m_valid, m_lt;

  comparator_arbiter #(.N(32), .REQS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_lt(rsp_lt)
  );

  comparator_arbiter #(.N(8), .REQS(3)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_id(rsp_id2), .rsp_lt(rsp_lt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] v, input int from);
    for (int k = 0; k < 4; k++)
      if (v[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_lt = 0;
  endtask

  // Called at a negedge with inputs set; checks, then advances one clock.
  task automatic step(input string tag);
    int g;
    logic [3:0] exp_rdy;
    logic signed [31:0] sa, sb;
    #1;
    g = (rst_n && (!m_valid || rsp_ready)) ? pick(req_valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    check({tag, ".rdy"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, ".vld"}, 64'(rsp_valid), 64'(m_valid));
    check({tag, ".id"},  64'(rsp_id),    64'(m_id));
    check({tag, ".lt"},  64'(rsp_lt),    64'(m_lt));
    last_grant = g;
    @(posedge clk);
    if (g >= 0) begin
      sa = req_a[g*32 +: 32];
      sb = req_b[g*32 +: 32];
      m_valid = 1; m_id = g; m_lt = (sa < sb); m_ptr = (g + 1) % 4;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic main_test();
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    int rr2_exp[3] = '{3, 1, 3};
    logic [31:0] ea[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    logic [31:0] eb[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000};
    bit el[6] = '{1, 0, 0, 1, 0, 0};
    bit pend[4];
    int xfers, cycles;

    rst_n = 0; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("por.vld", 64'(rsp_valid), 0);
    check("por.id",  64'(rsp_id),    0);
    check("por.lt",  64'(rsp_lt),    0);
    check("por.rdy", 64'(req_ready), 0);
    @(negedge clk);
    rst_n = 1;
    req_valid = 4'b0001;
    req_a[31:0] = -32'sd5;
    req_b[31:0] = 32'sd3;
    #1 check("single.rdy0", 64'(req_ready), 64'(4'b0001));
    step("single");
    check("single.vld", 64'(rsp_valid), 1);
    check("single.id",  64'(rsp_id),    0);
    check("single.lt",  64'(rsp_lt),    1);

    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = rnd32();
      req_b[i*32 +: 32] = rnd32();
    end
    step("fill");
    #2 rst_n = 0;
    #1;
    check("rst.vld", 64'(rsp_valid), 0);
    check("rst.id",  64'(rsp_id),    0);
    check("rst.lt",  64'(rsp_lt),    0);
    check("rst.rdy", 64'(req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    for (int k = 0; k < 6; k++) begin
      step("rr");
      check("rr.grant", 64'(last_grant), 64'(rr_exp[k]));
    end
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step("rr2");
      check("rr2.grant", 64'(last_grant), 64'(rr2_exp[k]));
    end

    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step("bp");
      check("bp.grant", 64'(last_grant), 64'(-1));
      check("bp.id",    64'(rsp_id),     3);
    end
    rsp_ready = 1;
    step("bp.drain");
    check("bp.regrant", 64'(last_grant), 1);
    check("bp.vld",     64'(rsp_valid),  1);
    check("bp.newid",   64'(rsp_id),     1);

    req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      req_a[31:0] = ea[k];
      req_b[31:0] = eb[k];
      step("edge");
      check("edge.lt", 64'(rsp_lt), 64'(el[k]));
    end
    req_valid = 4'b0000;
    step("idle");

    pend = '{default: 0};
    xfers = 0;
    cycles = 0;
    while (xfers < 10000 && cycles < 40000) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          req_a[i*32 +: 32] = rnd32();
          req_b[i*32 +: 32] = rnd32();
        end
        req_valid[i] = pend[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step("rnd");
      if (last_grant >= 0) begin
        pend[last_grant] = 0;
        xfers++;
      end
      cycles++;
    end
    check("rnd.budget", 64'(xfers >= 10000), 1);
    req_valid = 4'b0000;
    rsp_ready = 1;
    step("tail");
  endtask

  task automatic sweep_test();
    logic signed [7:0] sa, sb;
    bit exp;
    rst2_n = 0; req_valid2 = 3'b000; rsp_ready2 = 1; req_a2 = '0; req_b2 = '0;
    repeat (2) @(negedge clk);
    rst2_n = 1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        sa = 8'(a);
        sb = 8'(b);
        req_a2 = {sa, 16'h0};
        req_b2 = {sb, 16'h0};
        req_valid2 = 3'b100;
        #1 check("sw.rdy", 64'(req_ready2), 64'(3'b100));
        exp = (sa < sb);
        @(negedge clk);
        check("sw.lt", 64'(rsp_lt2), 64'(exp));
        check("sw.id", 64'(rsp_id2), 2);
      end
    end
    req_valid2 = 3'b000;
  endtask

  initial begin
    fork
      main_test();
      sweep_test();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
